run_sequencer: RTL

- Host-side controller for the other end of the processor's start/halt handshake.
- Runs a batch of NUM_PROGS programs back-to-back. For each program it drives the DUT start pulse, waits for halt and measures run cycles.
- Reports a per-program result record: cycles, timeout flag, program index.
- Sits between the testbench/host and the processor top level. prog_sel selects the instruction ROM image.

---
 rtl/run_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/run_sequencer.sv
// Host-side batch sequencer for the processor start/halt handshake: pulses start,
// measures RUN cycles until halt (or timeout) and reports one record per program.
module run_sequencer #(
    parameter int               START_CYCLES = 2,
    parameter int               CNT_W        = 16,
    parameter logic [CNT_W-1:0] TIMEOUT      = 16'd4095,
    parameter int               NUM_PROGS    = 3,
    parameter int               PROG_W       = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              run_req,
    input  logic              abort,
    input  logic              halt,
    output logic              start,
    output logic [PROG_W-1:0] prog_sel,
    output logic              busy,
    output logic              res_valid,
    output logic [CNT_W-1:0]  res_cycles,
    output logic              res_timeout,
    output logic              batch_done
);

    localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(START_CYCLES - 1);
    localparam logic [SC_W-1:0]   SC_ONE    = SC_W'(1);
    localparam logic [PROG_W-1:0] PROG_LAST = PROG_W'(NUM_PROGS - 1);
    localparam logic [PROG_W-1:0] PROG_ONE  = PROG_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic [PROG_W-1:0] prog_sel_q, prog_sel_d;
    logic              busy_q, busy_d;
    logic              res_valid_q, res_valid_d;
    logic [CNT_W-1:0]  res_cycles_q, res_cycles_d;
    logic              res_timeout_q, res_timeout_d;
    logic              batch_done_q, batch_done_d;
    logic [SC_W-1:0]   scnt_q, scnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state and next-output computation for the batch FSM.
    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        prog_sel_d    = prog_sel_q;
        busy_d        = busy_q;
        res_valid_d   = 1'b0;
        res_cycles_d  = res_cycles_q;
        res_timeout_d = res_timeout_q;
        batch_done_d  = 1'b0;
        scnt_d        = scnt_q;
        cnt_d         = cnt_q;

        if ((state_q != S_IDLE) && abort) begin
            state_d = S_IDLE;
            start_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_req && !abort) begin
                        state_d    = S_START;
                        start_d    = 1'b1;
                        busy_d     = 1'b1;
                        prog_sel_d = {PROG_W{1'b0}};
                        scnt_d     = {SC_W{1'b0}};
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (scnt_q == SC_LAST) begin
                        state_d = S_RUN;
                        start_d = 1'b0;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        scnt_d = scnt_q + SC_ONE;
                    end
                end
                S_RUN: begin
                    // A zero count marks the blanking cycle, where halt is not yet trusted.
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else if (halt || (cnt_q == TIMEOUT)) begin
                        state_d       = S_REPORT;
                        res_valid_d   = 1'b1;
                        res_cycles_d  = cnt_q;
                        res_timeout_d = !halt;
                        batch_done_d  = (prog_sel_q == PROG_LAST);
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_REPORT: begin
                    if (prog_sel_q == PROG_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = S_START;
                        start_d    = 1'b1;
                        prog_sel_d = prog_sel_q + PROG_ONE;
                        scnt_d     = {SC_W{1'b0}};
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    start_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; reset clears everything without waiting for a clock.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            prog_sel_q    <= {PROG_W{1'b0}};
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_cycles_q  <= {CNT_W{1'b0}};
            res_timeout_q <= 1'b0;
            batch_done_q  <= 1'b0;
            scnt_q        <= {SC_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            prog_sel_q    <= prog_sel_d;
            busy_q        <= busy_d;
            res_valid_q   <= res_valid_d;
            res_cycles_q  <= res_cycles_d;
            res_timeout_q <= res_timeout_d;
            batch_done_q  <= batch_done_d;
            scnt_q        <= scnt_d;
            cnt_q         <= cnt_d;
        end
    end

    assign start       = start_q;
    assign prog_sel    = prog_sel_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign res_cycles  = res_cycles_q;
    assign res_timeout = res_timeout_q;
    assign batch_done  = batch_done_q;

endmodule
